// File: rtl/audio_capture_if.sv
// Avalon-MM slave bus bundle for audio_capture.
// Handshake: a transfer occurs on every rising clk edge where chipselect is high
// together with read or write; there is no waitrequest, and readdata is valid one cycle later.
interface audio_capture_if;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata
    );
endinterface

// File: rtl/audio_capture.sv
// Triggered mono ADC recorder into on-chip BRAM with an Avalon-MM control and
// auto-incrementing readback port.
module audio_capture #(
    parameter int DEPTH    = 72000,
    parameter int PTR_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        advance,
    audio_capture_if.slave bus,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [PTR_BITS-1:0] DEPTH_P = PTR_BITS'(DEPTH);
    localparam logic [PTR_BITS-1:0] ONE_P   = PTR_BITS'(1);

    state_t              state, state_n;
    logic [PTR_BITS-1:0] wr_ptr, wr_ptr_n;
    logic [PTR_BITS-1:0] count, count_n;
    logic [PTR_BITS-1:0] rd_ptr, rd_addr, wd_ptr;
    logic [15:0]         threshold;
    logic [15:0]         mag;
    logic [15:0]         rd_q;
    logic                irq_n, mem_we, busy;
    logic                bus_rd, bus_wr, ctrl_wr, start, abort, irq_ack;
    logic                unused_bits;

    logic [15:0] mem [0:DEPTH-1];

    assign bus_rd   = bus.chipselect && bus.read;
    assign bus_wr   = bus.chipselect && bus.write;
    assign ctrl_wr  = bus_wr && (bus.address == 16'h0000);
    assign start    = ctrl_wr && bus.writedata[0];
    assign abort    = ctrl_wr && bus.writedata[1];
    assign irq_ack  = ctrl_wr && bus.writedata[2];
    assign busy     = (state == ARMED) || (state == CAPTURE);
    assign dbg_state = state;
    assign wd_ptr   = bus.writedata[PTR_BITS-1:0];
    assign rd_addr  = (rd_ptr < DEPTH_P) ? rd_ptr : '0;
    assign unused_bits = &{1'b0, bus.writedata[31:PTR_BITS]};

    // Magnitude is 16-bit unsigned so that -32768 maps to 32768 rather than wrapping.
    assign mag = sample_in[15] ? (~sample_in + 16'd1) : sample_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
            count  <= count_n;
            irq    <= irq_n;
        end
    end

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        count_n  = count;
        irq_n    = irq;
        mem_we   = 1'b0;
        // The sample strobe is evaluated against the state before any CTRL write.
        case (state)
            ARMED: begin
                if (advance && (mag >= threshold)) begin
                    mem_we   = 1'b1;
                    wr_ptr_n = ONE_P;
                    count_n  = ONE_P;
                    state_n  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (advance) begin
                    mem_we   = 1'b1;
                    wr_ptr_n = wr_ptr + ONE_P;
                    count_n  = count + ONE_P;
                    if (count_n == DEPTH_P) begin
                        state_n = DONE;
                        irq_n   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (abort) begin
            state_n  = IDLE;
            wr_ptr_n = wr_ptr;
            count_n  = count;
            irq_n    = irq;
            mem_we   = 1'b0;
        end else if (start && ((state == IDLE) || (state == DONE))) begin
            state_n  = ARMED;
            wr_ptr_n = '0;
            count_n  = '0;
            irq_n    = 1'b0;
        end
        if (irq_ack && !((state_n == DONE) && (state != DONE)))
            irq_n = 1'b0;
    end

    // BRAM: capture write port plus a read port that continuously prefetches rd_ptr.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr] <= sample_in;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            threshold    <= '0;
            bus.readdata <= '0;
        end else begin
            if (bus_wr) begin
                case (bus.address)
                    16'h0002: threshold <= bus.writedata[15:0];
                    16'h0003: rd_ptr    <= (wd_ptr > DEPTH_P) ? DEPTH_P : wd_ptr;
                    default: ;
                endcase
            end
            if (bus_rd) begin
                case (bus.address)
                    16'h0000: bus.readdata <= {28'b0, state, irq, busy};
                    16'h0001: bus.readdata <= {{(32-PTR_BITS){1'b0}}, count};
                    16'h0002: bus.readdata <= {16'b0, threshold};
                    16'h0003: bus.readdata <= {{(32-PTR_BITS){1'b0}}, rd_ptr};
                    16'h0004: begin
                        bus.readdata <= (rd_ptr < count) ? {{16{rd_q[15]}}, rd_q} : 32'd0;
                        if (rd_ptr != DEPTH_P)
                            rd_ptr <= rd_ptr + ONE_P;
                    end
                    default: bus.readdata <= 32'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_capture.sv
// Directed self-checking bench for audio_capture: trigger, full-depth capture,
// readback boundaries, abort/start/ack interactions.
module tb_audio_capture;

    logic        clk;
    logic        reset;
    logic [15:0] sample_in;
    logic        advance;
    logic        irq;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    audio_capture_if bus_if ();

    audio_capture dut (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .advance   (advance),
        .bus       (bus_if),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.address    = addr;
        bus_if.writedata  = data;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = addr;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        data = bus_if.readdata;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    // Scoreboard: DATA reads pop the next expected sample word.
    task automatic data_read(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        bus_read(16'h0004, d);
        e = exp_q.pop_front();
        check(tag, d, e);
    endtask

    task automatic adv(input logic [15:0] s);
        @(negedge clk);
        sample_in = s;
        advance   = 1'b1;
        @(negedge clk);
        advance   = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        sample_in = '0;
        advance = 1'b0;
        bus_if.chipselect = 1'b0;
        bus_if.read = 1'b0;
        bus_if.write = 1'b0;
        bus_if.address = '0;
        bus_if.writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        check("rst_readdata", bus_if.readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        read_check("rst_status", 16'h0000, 32'h0);
        read_check("rst_count", 16'h0001, 32'h0);

        // Reset in the middle of a capture
        bus_write(16'h0000, 32'h1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sample_in = 16'(i);
            advance = 1'b1;
        end
        @(negedge clk);
        advance = 1'b0;
        read_check("mid_count", 16'h0001, 32'd100);
        read_check("mid_status", 16'h0000, 32'h9);
        reset = 1'b0;
        #1;
        check("mid_rst_readdata", bus_if.readdata, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        read_check("post_rst_status", 16'h0000, 32'h0);
        read_check("post_rst_count", 16'h0001, 32'h0);

        // Full-depth capture, threshold 0
        bus_write(16'h0000, 32'h1);
        for (int i = 0; i < 71999; i++) begin
            @(negedge clk);
            sample_in = 16'(i);
            advance = 1'b1;
        end
        @(negedge clk);
        advance = 1'b0;
        check("full_71999_state", {30'd0, dbg_state}, 32'd2);
        check("full_71999_irq", {31'd0, irq}, 32'd0);
        adv(16'(71999));
        check("full_done_state", {30'd0, dbg_state}, 32'd3);
        check("full_done_irq", {31'd0, irq}, 32'd1);
        read_check("full_count", 16'h0001, 32'd72000);
        read_check("full_status", 16'h0000, 32'hE);
        bus_write(16'h0003, 32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        data_read("full_data0");
        data_read("full_data1");
        data_read("full_data2");
        bus_write(16'h0003, 32'd71999);
        exp_q.push_back(32'h0000193F);
        exp_q.push_back(32'd0);
        data_read("full_data_last");
        data_read("full_data_past_end");
        read_check("rdptr_saturate", 16'h0003, 32'd72000);

        // IRQ acknowledge, then restart from DONE
        bus_write(16'h0000, 32'h4);
        check("ack_irq", {31'd0, irq}, 32'd0);
        read_check("ack_status", 16'h0000, 32'hC);
        bus_write(16'h0000, 32'h1);
        read_check("restart_status", 16'h0000, 32'h5);
        read_check("restart_count", 16'h0001, 32'd0);

        // Level trigger at threshold 1000
        bus_write(16'h0000, 32'h2);
        read_check("abort_status", 16'h0000, 32'h0);
        bus_write(16'h0002, 32'd1000);
        read_check("thresh_rb", 16'h0002, 32'd1000);
        bus_write(16'h0000, 32'h1);
        adv(16'd10);
        adv(16'hFC19);
        read_check("thr_armed", 16'h0000, 32'h5);
        adv(16'hFC18);
        read_check("thr_capture", 16'h0000, 32'h9);
        adv(16'd5);
        read_check("thr_count", 16'h0001, 32'd2);
        bus_write(16'h0003, 32'd0);
        exp_q.push_back(32'hFFFFFC18);
        exp_q.push_back(32'h00000005);
        data_read("thr_data0");
        data_read("thr_data1");

        // -32768 magnitude edge
        bus_write(16'h0000, 32'h2);
        bus_write(16'h0002, 32'hFFFF);
        bus_write(16'h0000, 32'h1);
        adv(16'h8000);
        read_check("neg_ffff_status", 16'h0000, 32'h5);
        read_check("neg_ffff_count", 16'h0001, 32'd0);
        bus_write(16'h0002, 32'h8000);
        adv(16'h8000);
        read_check("neg_8000_status", 16'h0000, 32'h9);
        read_check("neg_8000_count", 16'h0001, 32'd1);

        // START|ABORT coincident with advance at count 50
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            sample_in = 16'(i);
            advance = 1'b1;
        end
        @(negedge clk);
        advance = 1'b0;
        read_check("pre_abort_count", 16'h0001, 32'd50);
        @(negedge clk);
        bus_if.chipselect = 1'b1;
        bus_if.write = 1'b1;
        bus_if.address = 16'h0000;
        bus_if.writedata = 32'h3;
        sample_in = 16'h7777;
        advance = 1'b1;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write = 1'b0;
        advance = 1'b0;
        read_check("abort_adv_status", 16'h0000, 32'h0);
        read_check("abort_adv_count", 16'h0001, 32'd50);
        bus_write(16'h0003, 32'd0);
        exp_q.push_back(32'hFFFF8000);
        data_read("abort_data0");
        bus_write(16'h0003, 32'd49);
        exp_q.push_back(32'd49);
        exp_q.push_back(32'd0);
        data_read("abort_data49");
        data_read("abort_data50");

        // Unmapped accesses
        bus_write(16'h0010, 32'hFFFFFFFF);
        read_check("unmapped_read", 16'h0005, 32'h0);
        read_check("thresh_kept", 16'h0002, 32'h8000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
